// File: rtl/bfis_beam_search.sv
// Best-first beam search engine: sorted beam list, visited bitmap, streamed top-k results.
// Optional BFIS_STATS_EN enables per-search evaluation/expansion statistics counters.
module bfis_beam_search #(
  parameter int ADDR_W    = 32,
  parameter int DIST_W    = 32,
  parameter int K_MAX     = 8,
  parameter int N_VERT    = 256,
  parameter int MAX_ITERS = 64
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] entry_addr_in,
  input  logic [15:0]       k_in,
  input  logic [15:0]       max_iters_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              nbr_req_valid_out,
  output logic [ADDR_W-1:0] nbr_req_addr_out,
  input  logic              nbr_req_ready_in,
  input  logic              nbr_valid_in,
  input  logic [ADDR_W-1:0] nbr_addr_in,
  input  logic              nbr_done_in,
  output logic              nbr_ready_out,
  output logic              dist_req_valid_out,
  output logic [ADDR_W-1:0] dist_req_addr_out,
  input  logic              dist_req_ready_in,
  input  logic              dist_resp_valid_in,
  input  logic [ADDR_W-1:0] dist_resp_addr_in,
  input  logic [DIST_W-1:0] dist_resp_in,
  output logic              res_valid_out,
  output logic [ADDR_W-1:0] res_addr_out,
  output logic [DIST_W-1:0] res_dist_out,
  output logic              res_last_out,
  input  logic              res_ready_in,
  output logic [15:0]       stat_evals_out,
  output logic [15:0]       stat_iters_out
);
  // state     | meaning
  // IDLE      | waiting for start
  // CLEAR     | bitmap/list cleared, entry distance request loaded
  // SEED      | entry marked visited
  // WAIT_SEED | waiting for entry distance
  // SELECT    | pick first unchecked beam entry or finish
  // NREQ      | neighbour-list request held until accepted
  // EXPAND    | consuming neighbour beats, issuing distance requests
  // WAIT      | waiting for outstanding distances
  // DRAIN     | streaming sorted results
  // DONE      | done pulse
  localparam int IDX_W = $clog2(N_VERT);
  localparam int KI_W  = $clog2(K_MAX + 1);
  localparam int LI_W  = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int OUT_W = $clog2(K_MAX * N_VERT);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_SEED, S_WAIT_SEED, S_SELECT, S_NREQ, S_EXPAND, S_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [N_VERT-1:0] visited;
  logic [DIST_W-1:0] l_dist [K_MAX];
  logic [ADDR_W-1:0] l_addr [K_MAX];
  logic [K_MAX-1:0]  l_chk;
  logic [KI_W-1:0]   l_size;
  logic [KI_W-1:0]   k_eff;
  logic [KI_W-1:0]   k_clamp;
  logic [15:0]       budget;
  logic [15:0]       iters;
  logic [OUT_W-1:0]  outstanding;
  logic [LI_W-1:0]   rd_idx;

  logic              resp_take, resp_dec, ins_drop, nbr_take, nbr_new, nbr_in_range;
  logic [KI_W-1:0]   ins_pos;
  logic              sel_found, sel_go;
  logic [LI_W-1:0]   sel_idx;

  assign k_clamp = (k_in == 16'd0) ? KI_W'(1) :
                   (k_in > 16'(K_MAX)) ? KI_W'(K_MAX) : k_in[KI_W-1:0];

  assign resp_take = dist_resp_valid_in &&
                     (state == S_SEED || state == S_WAIT_SEED || state == S_EXPAND || state == S_WAIT);
  assign resp_dec  = resp_take && (outstanding != '0);

  assign nbr_take     = (state == S_EXPAND) && nbr_valid_in && nbr_ready_out;
  assign nbr_in_range = nbr_addr_in < ADDR_W'(N_VERT);
  assign nbr_new      = nbr_take && !nbr_done_in && nbr_in_range && !visited[nbr_addr_in[IDX_W-1:0]];

  // Insertion slot = count of entries with dist <= new dist, so ties land after equals.
  always_comb begin
    ins_pos = '0;
    for (int i = 0; i < K_MAX; i++)
      if (KI_W'(i) < l_size && l_dist[i] <= dist_resp_in) ins_pos = ins_pos + KI_W'(1);
    ins_drop = (l_size == k_eff) && (ins_pos == l_size);
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = K_MAX - 1; i >= 0; i--)
      if (KI_W'(i) < l_size && !l_chk[i]) begin
        sel_found = 1'b1;
        sel_idx   = LI_W'(i);
      end
    sel_go = sel_found && (iters < budget);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start_in) state_nxt = S_CLEAR;
      S_CLEAR:     state_nxt = S_SEED;
      S_SEED:      state_nxt = S_WAIT_SEED;
      S_WAIT_SEED: if (outstanding == '0) state_nxt = S_SELECT;
      S_SELECT:    state_nxt = sel_go ? S_NREQ : S_DRAIN;
      S_NREQ:      if (nbr_req_ready_in) state_nxt = S_EXPAND;
      S_EXPAND:    if (nbr_take && nbr_done_in) state_nxt = S_WAIT;
      S_WAIT:      if (outstanding == '0) state_nxt = S_SELECT;
      S_DRAIN:     if (l_size == '0 || (res_ready_in && res_last_out)) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_out      = (state != S_IDLE);
    done_out      = (state == S_DONE);
    nbr_ready_out = (state == S_EXPAND) && (!dist_req_valid_out || dist_req_ready_in);
    res_valid_out = (state == S_DRAIN) && (l_size != '0);
    res_last_out  = res_valid_out && (KI_W'(rd_idx) == l_size - KI_W'(1));
    res_addr_out  = res_valid_out ? l_addr[rd_idx] : '0;
    res_dist_out  = res_valid_out ? l_dist[rd_idx] : '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      k_eff <= '0; budget <= '0; iters <= '0; outstanding <= '0; rd_idx <= '0;
      nbr_req_valid_out <= 1'b0; nbr_req_addr_out <= '0;
      dist_req_valid_out <= 1'b0; dist_req_addr_out <= '0;
    end else begin
      if (state == S_IDLE && start_in) begin
        k_eff             <= k_clamp;
        budget            <= (max_iters_in == 16'd0) ? 16'(MAX_ITERS) : max_iters_in;
        dist_req_addr_out <= entry_addr_in;
      end
      if (state == S_CLEAR) begin
        iters              <= '0;
        rd_idx             <= '0;
        outstanding        <= OUT_W'(1);
        dist_req_valid_out <= 1'b1;
      end else begin
        if (nbr_new) begin
          dist_req_valid_out <= 1'b1;
          dist_req_addr_out  <= nbr_addr_in;
        end else if (dist_req_ready_in) begin
          dist_req_valid_out <= 1'b0;
        end
        if (nbr_new && !resp_dec)      outstanding <= outstanding + OUT_W'(1);
        else if (!nbr_new && resp_dec) outstanding <= outstanding - OUT_W'(1);
      end
      if (state == S_SELECT && sel_go) begin
        iters             <= iters + 16'd1;
        nbr_req_valid_out <= 1'b1;
        nbr_req_addr_out  <= l_addr[sel_idx];
      end else if (state == S_NREQ && nbr_req_ready_in) begin
        nbr_req_valid_out <= 1'b0;
      end
      if (res_valid_out && res_ready_in && !res_last_out) rd_idx <= rd_idx + LI_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || state == S_CLEAR) begin
      visited <= '0;
    end else if (state == S_SEED) begin
      if (dist_req_addr_out < ADDR_W'(N_VERT)) visited[dist_req_addr_out[IDX_W-1:0]] <= 1'b1;
    end else if (nbr_new) begin
      visited[nbr_addr_in[IDX_W-1:0]] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < K_MAX; i++) begin
        l_dist[i] <= '0;
        l_addr[i] <= '0;
      end
      l_chk  <= '0;
      l_size <= '0;
    end else if (state == S_CLEAR) begin
      l_chk  <= '0;
      l_size <= '0;
    end else if (resp_take && !ins_drop) begin
      for (int i = 1; i < K_MAX; i++)
        if (KI_W'(i) > ins_pos) begin
          l_dist[i] <= l_dist[i-1];
          l_addr[i] <= l_addr[i-1];
          l_chk[i]  <= l_chk[i-1];
        end
      l_dist[ins_pos[LI_W-1:0]] <= dist_resp_in;
      l_addr[ins_pos[LI_W-1:0]] <= dist_resp_addr_in;
      l_chk[ins_pos[LI_W-1:0]]  <= 1'b0;
      if (l_size != k_eff) l_size <= l_size + KI_W'(1);
    end else if (state == S_SELECT && sel_go) begin
      l_chk[sel_idx] <= 1'b1;
    end
  end

`ifdef BFIS_STATS_EN
  logic [15:0] evals;

  always_ff @(posedge clk_in) begin
    if (rst_in || state == S_CLEAR) evals <= '0;
    else if (dist_req_valid_out && dist_req_ready_in && evals != 16'hFFFF) evals <= evals + 16'd1;
  end

  // iters never exceeds the 16-bit budget, so it is already saturated by construction.
  assign stat_evals_out = evals;
  assign stat_iters_out = iters;
`else
  assign stat_evals_out = '0;
  assign stat_iters_out = '0;
`endif

endmodule

// File: tb/tb_bfis_beam_search.sv
// Directed bench for bfis_beam_search: fixed graph (path 0-3, isolated 5, triangle 8-10)
// served by behavioural neighbour/distance units; results checked against hand-derived values.
module tb_bfis_beam_search;
  logic        clk;
  logic        rst_in, start_in;
  logic [31:0] entry_addr_in;
  logic [15:0] k_in, max_iters_in;
  logic        busy_out, done_out;
  logic        nbr_req_valid_out, nbr_req_ready_in;
  logic [31:0] nbr_req_addr_out;
  logic        nbr_valid_in, nbr_done_in, nbr_ready_out;
  logic [31:0] nbr_addr_in;
  logic        dist_req_valid_out, dist_req_ready_in, dist_resp_valid_in;
  logic [31:0] dist_req_addr_out, dist_resp_addr_in, dist_resp_in;
  logic        res_valid_out, res_last_out, res_ready_in;
  logic [31:0] res_addr_out, res_dist_out;
  logic [15:0] stat_evals_out, stat_iters_out;

  bfis_beam_search dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .entry_addr_in(entry_addr_in),
    .k_in(k_in), .max_iters_in(max_iters_in), .busy_out(busy_out), .done_out(done_out),
    .nbr_req_valid_out(nbr_req_valid_out), .nbr_req_addr_out(nbr_req_addr_out),
    .nbr_req_ready_in(nbr_req_ready_in), .nbr_valid_in(nbr_valid_in), .nbr_addr_in(nbr_addr_in),
    .nbr_done_in(nbr_done_in), .nbr_ready_out(nbr_ready_out),
    .dist_req_valid_out(dist_req_valid_out), .dist_req_addr_out(dist_req_addr_out),
    .dist_req_ready_in(dist_req_ready_in), .dist_resp_valid_in(dist_resp_valid_in),
    .dist_resp_addr_in(dist_resp_addr_in), .dist_resp_in(dist_resp_in),
    .res_valid_out(res_valid_out), .res_addr_out(res_addr_out), .res_dist_out(res_dist_out),
    .res_last_out(res_last_out), .res_ready_in(res_ready_in),
    .stat_evals_out(stat_evals_out), .stat_iters_out(stat_iters_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run, tests_failed;

  logic [31:0] adj [16][4];
  int          adj_n [16];
  logic [31:0] dtab [16];

  int          nres, done_seen, evals_seen, nreq_seen;
  int          req_cnt [16];
  logic [31:0] r_addr [16];
  logic [31:0] r_dist [16];
  logic        r_last [16];
  bit          rand_dreq;
  int          stall;

  // Behavioural fetch/distance units and result sink, all acting on the falling edge.
  initial begin : service
    bit          req_hs, beat_hs, dreq_hs, res_hs, fetching;
    logic [31:0] rec_daddr, rec_raddr, rec_rdist, fv, a;
    logic        rec_rlast;
    int          fj;
    logic [31:0] dq [$];
    req_hs = 0; beat_hs = 0; dreq_hs = 0; res_hs = 0; fetching = 0; fj = 0; fv = '0;
    rec_daddr = '0; rec_raddr = '0; rec_rdist = '0; rec_rlast = 0;
    nbr_req_ready_in = 0; nbr_valid_in = 0; nbr_addr_in = '0; nbr_done_in = 0;
    dist_req_ready_in = 0; dist_resp_valid_in = 0; dist_resp_addr_in = '0; dist_resp_in = '0;
    res_ready_in = 0;
    forever begin
      @(negedge clk);
      if (rst_in) begin
        req_hs = 0; beat_hs = 0; dreq_hs = 0; res_hs = 0; fetching = 0;
        dq.delete();
        nbr_req_ready_in = 0; nbr_valid_in = 0; nbr_done_in = 0; nbr_addr_in = '0;
        dist_req_ready_in = 0; dist_resp_valid_in = 0; res_ready_in = 0;
      end else begin
        if (req_hs) begin fetching = 1; fv = nbr_req_addr_out; fj = 0; nreq_seen++; end
        if (beat_hs) begin
          if (nbr_done_in) fetching = 0;
          else fj++;
        end
        if (dreq_hs) begin
          dq.push_back(rec_daddr);
          evals_seen++;
          req_cnt[rec_daddr[3:0]]++;
        end
        if (res_hs && nres < 16) begin
          r_addr[nres] = rec_raddr; r_dist[nres] = rec_rdist; r_last[nres] = rec_rlast;
          nres++;
        end
        if (done_out) done_seen++;

        nbr_req_ready_in = 1;
        if (fetching) begin
          nbr_valid_in = 1;
          if (fj < adj_n[fv[3:0]]) begin nbr_addr_in = adj[fv[3:0]][fj]; nbr_done_in = 0; end
          else begin nbr_addr_in = '0; nbr_done_in = 1; end
        end else begin
          nbr_valid_in = 0; nbr_done_in = 0; nbr_addr_in = '0;
        end
        dist_req_ready_in = rand_dreq ? 1'($urandom_range(0, 1)) : 1'b1;
        if (dq.size() > 0) begin
          a = dq.pop_front();
          dist_resp_valid_in = 1; dist_resp_addr_in = a; dist_resp_in = dtab[a[3:0]];
        end else begin
          dist_resp_valid_in = 0;
        end
        if (stall > 0 && res_valid_out) stall--;
        res_ready_in = (stall == 0);

        #1;
        req_hs  = nbr_req_valid_out && nbr_req_ready_in;
        beat_hs = nbr_valid_in && nbr_ready_out;
        dreq_hs = dist_req_valid_out && dist_req_ready_in;
        rec_daddr = dist_req_addr_out;
        res_hs  = res_valid_out && res_ready_in;
        rec_raddr = res_addr_out; rec_rdist = res_dist_out; rec_rlast = res_last_out;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int i, input logic [31:0] a,
                            input logic [31:0] d, input logic l);
    check({tag, "_addr"}, r_addr[i], a);
    check({tag, "_dist"}, r_dist[i], d);
    check({tag, "_last"}, r_last[i], l);
  endtask

  task automatic check_stats(input string tag, input int it, input int ev);
`ifdef BFIS_STATS_EN
    check({tag, "_stat_iters"}, stat_iters_out, it);
    check({tag, "_stat_evals"}, stat_evals_out, ev);
`else
    check({tag, "_stat_iters"}, stat_iters_out, 0);
    check({tag, "_stat_evals"}, stat_evals_out, 0);
`endif
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_done"}, done_out, 0);
    check({tag, "_res_valid"}, res_valid_out, 0);
    check({tag, "_nbr_req_valid"}, nbr_req_valid_out, 0);
    check({tag, "_dist_req_valid"}, dist_req_valid_out, 0);
    check({tag, "_nbr_ready"}, nbr_ready_out, 0);
    check({tag, "_stat_evals0"}, stat_evals_out, 0);
    check({tag, "_stat_iters0"}, stat_iters_out, 0);
  endtask

  task automatic launch(input logic [31:0] e, input logic [15:0] k, input logic [15:0] it);
    nres = 0; done_seen = 0; evals_seen = 0; nreq_seen = 0;
    for (int i = 0; i < 16; i++) req_cnt[i] = 0;
    entry_addr_in = e; k_in = k; max_iters_in = it; start_in = 1;
  endtask

  task automatic run_search(input string tag, input logic [31:0] e, input logic [15:0] k,
                            input logic [15:0] it, input bit lat);
    int n;
    launch(e, k, it);
    step();
    start_in = 0;
    if (lat) begin
      check({tag, "_busy_after_start"}, busy_out, 1);
      check({tag, "_lat_cycle1"}, dist_req_valid_out, 0);
    end
    step();
    if (lat) check({tag, "_lat_cycle2"}, dist_req_valid_out, 1);
    n = 0;
    while (done_seen == 0 && n < 3000) begin step(); n++; end
    step(); step();
    check({tag, "_done_pulses"}, done_seen, 1);
    check({tag, "_busy_end"}, busy_out, 0);
  endtask

  initial begin : stimulus
    rst_in = 1; start_in = 0; entry_addr_in = '0; k_in = '0; max_iters_in = '0;
    tests_run = 0; tests_failed = 0; rand_dreq = 0; stall = 0;
    nres = 0; done_seen = 0; evals_seen = 0; nreq_seen = 0;
    for (int i = 0; i < 16; i++) begin
      adj_n[i] = 0; dtab[i] = 32'd1000; req_cnt[i] = 0;
      r_addr[i] = '0; r_dist[i] = '0; r_last[i] = 0;
      for (int j = 0; j < 4; j++) adj[i][j] = '0;
    end
    adj_n[0] = 1; adj[0][0] = 1;
    adj_n[1] = 2; adj[1][0] = 0; adj[1][1] = 2;
    adj_n[2] = 2; adj[2][0] = 1; adj[2][1] = 3;
    adj_n[3] = 1; adj[3][0] = 2;
    dtab[0] = 30; dtab[1] = 20; dtab[2] = 10; dtab[3] = 0;
    dtab[5] = 100;
    adj_n[8]  = 2; adj[8][0]  = 9; adj[8][1]  = 10;
    adj_n[9]  = 2; adj[9][0]  = 8; adj[9][1]  = 10;
    adj_n[10] = 2; adj[10][0] = 8; adj[10][1] = 9;
    dtab[8] = 5; dtab[9] = 6; dtab[10] = 7;

    repeat (3) step();
    check_quiet("reset");
    rst_in = 0;
    step();

    // isolated vertex: one beat, one expansion, one evaluation
    run_search("t2", 32'd5, 16'd8, 16'd0, 1);
    check("t2_nres", nres, 1);
    check_beat("t2_b0", 0, 32'd5, 32'd100, 1);
    check("t2_evals", evals_seen, 1);
    check("t2_iters", nreq_seen, 1);
    check_stats("t2", 1, 1);

    // path 0-1-2-3, k=2
    run_search("t3", 32'd0, 16'd2, 16'd0, 0);
    check("t3_nres", nres, 2);
    check_beat("t3_b0", 0, 32'd3, 32'd0, 0);
    check_beat("t3_b1", 1, 32'd2, 32'd10, 1);
    check("t3_evals", evals_seen, 4);
    check("t3_iters", nreq_seen, 4);
    check_stats("t3", 4, 4);

    // triangle 8-9-10: every vertex evaluated exactly once
    run_search("t4", 32'd8, 16'd3, 16'd0, 0);
    check("t4_evals", evals_seen, 3);
    check("t4_req8", req_cnt[8], 1);
    check("t4_req9", req_cnt[9], 1);
    check("t4_req10", req_cnt[10], 1);
    check("t4_nres", nres, 3);
    check_beat("t4_b0", 0, 32'd8, 32'd5, 0);
    check_beat("t4_b2", 2, 32'd10, 32'd7, 1);
    check("t4_iters", nreq_seen, 3);

    // backpressure on distance requests and result sink
    rand_dreq = 1; stall = 10;
    run_search("t5", 32'd0, 16'd2, 16'd0, 0);
    rand_dreq = 0; stall = 0;
    check("t5_nres", nres, 2);
    check_beat("t5_b0", 0, 32'd3, 32'd0, 0);
    check_beat("t5_b1", 1, 32'd2, 32'd10, 1);
    check("t5_evals", evals_seen, 4);

    // single-expansion budget
    run_search("t6a", 32'd0, 16'd2, 16'd1, 0);
    check("t6a_nres", nres, 2);
    check_beat("t6a_b0", 0, 32'd1, 32'd20, 0);
    check_beat("t6a_b1", 1, 32'd0, 32'd30, 1);
    check("t6a_iters", nreq_seen, 1);
    check_stats("t6a", 1, 2);

    // k=0 clamps to 1
    run_search("t6b", 32'd0, 16'd0, 16'd0, 0);
    check("t6b_nres", nres, 1);
    check_beat("t6b_b0", 0, 32'd3, 32'd0, 1);

    // k=20 clamps to K_MAX; only 4 vertices reachable
    run_search("t6c", 32'd0, 16'd20, 16'd0, 0);
    check("t6c_nres", nres, 4);
    check_beat("t6c_b0", 0, 32'd3, 32'd0, 0);
    check_beat("t6c_b3", 3, 32'd0, 32'd30, 1);

    // reset in the middle of a search, then a clean search
    launch(32'd0, 16'd2, 16'd0);
    step();
    start_in = 0;
    repeat (6) step();
    rst_in = 1;
    step(); step();
    check_quiet("t1_midrst");
    rst_in = 0;
    step();
    run_search("t1_after", 32'd5, 16'd8, 16'd0, 1);
    check("t1_nres", nres, 1);
    check_beat("t1_b0", 0, 32'd5, 32'd100, 1);
    check("t1_evals", evals_seen, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
